id_pipe: RTL and testbench
==========================

# id_pipe

Registered, handshaked instruction-decode stage sitting between the fetch stage and the execute stage of the pipelined core. It decodes one instruction per cycle and reads two register-file ports. Operands are forwarded from the EX and MEM stages, and a load-use hazard inserts a bubble. Results go out through a valid/ready pipeline register, and a flush input squashes in-flight work.

## Interface
- `XLEN`, 32, data/register width
- `RADDR_W`, 5, register address width; register 0 reads as zero
- `AW`, 32, instruction address width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high (`RstEnable` = 1)
- `flush`  in  1  squash the stage contents and the output register
- `if_valid`  in  1  fetch presents an instruction
- `if_pc`  in  AW  instruction address
- `if_inst`  in  32  instruction word
- `id_ready`  out  1  stage accepts the instruction this cycle
- `reg1_read_o`, `reg2_read_o`  out  1  regfile read enables (combinational)
- `reg1_addr_o`, `reg2_addr_o`  out  RADDR_W  regfile read addresses = inst[25:21], inst[20:16]
- `reg1_data_i`, `reg2_data_i`  in  XLEN  regfile read data, same cycle
- `ex_wreg_i`, `ex_load_i`  in  1  EX result write enable; EX instruction is a load
- `ex_wd_i`  in  RADDR_W  EX destination register
- `ex_wdata_i`  in  XLEN  EX result
- `mem_wreg_i`  in  1  MEM result write enable
- `mem_wd_i`  in  RADDR_W  MEM destination register
- `mem_wdata_i`  in  XLEN  MEM result
- `ex_valid`  out  1  output register holds a decoded instruction
- `ex_ready`  in  1  execute consumes it
- `pc_o`  out  AW  registered PC
- `aluop_o`, `alusel_o`  out  `AluOpBus`, `AluSelBus`  registered operation and result select
- `reg1_o`, `reg2_o`  out  XLEN  registered operands
- `wd_o`  out  RADDR_W  registered destination
- `wreg_o`  out  1  registered write enable
- `inst_invalid_o`  out  1  registered illegal-opcode flag

## Operation
- Decode uses op = inst[31:26] and funct = inst[5:0].
  - ORI/ANDI/XORI: rs plus zero-extended imm16; destination rt; alusel LOGIC.
  - LUI: {imm16, 16'b0}; reg1 = 0; destination rt.
  - SPECIAL with funct OR/AND/XOR/NOR: rs, rt; destination rd.
  - LW: rs plus sign-extended imm16; destination rt; load flag carried in aluop.
- Any other opcode: aluop NOP, wreg 0, inst_invalid 1. It still flows through the pipeline.
- Operand select, per port:
  - port not read → imm;
  - address 0 → 0;
  - EX match with ex_wreg and not ex_load → ex_wdata;
  - else MEM match with mem_wreg → mem_wdata;
  - else regfile data.
  - EX has priority over MEM.
- Stall: if_valid, ex_load_i, ex_wreg_i, and ex_wd_i ≠ 0 equal to an enabled read address. While stalled, id_ready = 0.
- id_ready = !stall && (!ex_valid || ex_ready). Accept = if_valid && id_ready.
- Output register update on each clock edge:
  - flush → ex_valid 0;
  - else accept → load the decoded fields, ex_valid 1;
  - else ex_ready → ex_valid 0, which is the stall bubble;
  - else hold.
- While ex_valid && !ex_ready, all output fields are stable.
- wreg_o and aluop_o are forced to 0/NOP whenever ex_valid = 0.

## Timing
- Latency is 1 cycle: accepted at edge N, visible on the outputs after edge N.
- Throughput is 1 instruction per cycle when there is no stall and ex_ready = 1.
- Load-use costs exactly one bubble, because the load moves to MEM on the next cycle and forwarding from MEM then applies.
- Flush beats accept and stall in the same cycle; id_ready is not gated by flush.
- Reset values, applied asynchronously:
  - ex_valid, wreg_o, inst_invalid_o: 0;
  - aluop_o: `EXE_NOP_OP`; alusel_o: `EXE_RES_NOP`;
  - reg1_o, reg2_o, pc_o: zero; wd_o: `NOPRegAddr`.
- Reset asserted mid-stall clears everything. The first accept can happen in the first cycle after reset deasserts.

## Structure
- Shared defs package holds:
  - opcode/funct constants (`EXE_ORI`, `EXE_ANDI`, `EXE_XORI`, `EXE_LUI`, `EXE_SPECIAL`, `EXE_LW`, funct codes);
  - `AluOpBus`/`AluSelBus` widths and `EXE_*_OP`/`EXE_RES_*` values;
  - `RstEnable`, `ReadEnable`, `WriteEnable`, `ZeroWord`, `NOPRegAddr`.
- Sub-module `id_decode`: pure combinational decode of the instruction into fields and imm.
- `id_pipe`: forwarding, hazard detection and the output register.

## Test plan
- Reset release, then ORI $2,$1,0x00FF with regfile $1 = 0x12340000 → next cycle: ex_valid 1, reg1 0x12340000, reg2 0x000000FF, wd 2, wreg 1.
- Forwarding priority:
  - OR $3,$2,$2 with EX writing $2 = 0xAAAA0000 and MEM writing $2 = 0x5555 → reg1 = reg2 = 0xAAAA0000.
  - Same case with EX not writing → 0x5555.
  - Any operand addressed as $0 → 0 regardless of forwarding.
- Load-use: EX is LW with wd 4, ID holds ANDI $5,$4,1 → id_ready 0 for 1 cycle and one bubble (ex_valid 0). The next cycle forwards MEM data 0x7 → reg1 0x7.
- Backpressure: ex_ready held 0 for 3 cycles with if_valid 1 → outputs stable and id_ready 0. Once ready returns, instructions issue in order with none lost or duplicated.
- Flush with a stall and a valid output present → ex_valid 0 on the next cycle. Asserting rst mid-stream clears all outputs asynchronously to the reset values.
- Opcode 0x3F → inst_invalid 1, wreg 0, aluop NOP, ex_valid 1.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes, ALU
// operation/select encodings and the reset/enable constants.
package id_pipe_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ReadEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    localparam int AluOpBusWidth  = 8;
    localparam int AluSelBusWidth = 3;
    typedef logic [AluOpBusWidth-1:0]  AluOpBus;
    typedef logic [AluSelBusWidth-1:0] AluSelBus;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;
    localparam logic [5:0] EXE_LW      = 6'b100011;

    // SPECIAL funct codes, inst[5:0]
    localparam logic [5:0] EXE_AND = 6'b100100;
    localparam logic [5:0] EXE_OR  = 6'b100101;
    localparam logic [5:0] EXE_XOR = 6'b100110;
    localparam logic [5:0] EXE_NOR = 6'b100111;

    localparam AluOpBus EXE_NOP_OP = 8'b0000_0000;
    localparam AluOpBus EXE_AND_OP = 8'b0010_0100;
    localparam AluOpBus EXE_OR_OP  = 8'b0010_0101;
    localparam AluOpBus EXE_XOR_OP = 8'b0010_0110;
    localparam AluOpBus EXE_NOR_OP = 8'b0010_0111;
    localparam AluOpBus EXE_LW_OP  = 8'b1110_0011;

    localparam AluSelBus EXE_RES_NOP        = 3'b000;
    localparam AluSelBus EXE_RES_LOGIC      = 3'b001;
    localparam AluSelBus EXE_RES_LOAD_STORE = 3'b111;

endpackage

// File: rtl/id_pipe_decode.sv
// Pure combinational instruction decode: ALU operation, result select,
// destination, register-read enables and the immediate operand.
module id_decode
    import id_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output AluOpBus         aluop,
    output AluSelBus        alusel,
    output logic            wreg,
    output logic [4:0]      wd,
    output logic            reg1_read,
    output logic            reg2_read,
    output logic [XLEN-1:0] imm,
    output logic            inst_invalid
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        unused_fields;

    assign op    = inst[31:26];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign funct = inst[5:0];
    assign imm16 = inst[15:0];
    // rs goes straight to the regfile address port; shamt is never used here.
    assign unused_fields = ^{inst[25:21], inst[10:6]};

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        aluop        = EXE_NOP_OP;
        alusel       = EXE_RES_NOP;
        wreg         = ~WriteEnable;
        wd           = NOPRegAddr;
        reg1_read    = ~ReadEnable;
        reg2_read    = ~ReadEnable;
        imm          = '0;
        inst_invalid = 1'b1;

        case (op)
            EXE_ORI, EXE_ANDI, EXE_XORI: begin
                aluop        = (op == EXE_ORI)  ? EXE_OR_OP  :
                               (op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
                alusel       = EXE_RES_LOGIC;
                wreg         = WriteEnable;
                wd           = rt;
                reg1_read    = ReadEnable;
                imm          = XLEN'(imm16);
                inst_invalid = 1'b0;
            end
            EXE_LUI: begin
                // Neither port is read: reg1 falls back to zero, reg2 to the shifted imm.
                aluop        = EXE_OR_OP;
                alusel       = EXE_RES_LOGIC;
                wreg         = WriteEnable;
                wd           = rt;
                imm          = XLEN'({imm16, 16'h0000});
                inst_invalid = 1'b0;
            end
            EXE_LW: begin
                aluop        = EXE_LW_OP;
                alusel       = EXE_RES_LOAD_STORE;
                wreg         = WriteEnable;
                wd           = rt;
                reg1_read    = ReadEnable;
                imm          = XLEN'(signed'(imm16));
                inst_invalid = 1'b0;
            end
            EXE_SPECIAL: begin
                case (funct)
                    EXE_OR, EXE_AND, EXE_XOR, EXE_NOR: begin
                        aluop        = (funct == EXE_OR)  ? EXE_OR_OP  :
                                       (funct == EXE_AND) ? EXE_AND_OP :
                                       (funct == EXE_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
                        alusel       = EXE_RES_LOGIC;
                        wreg         = WriteEnable;
                        wd           = rd;
                        reg1_read    = ReadEnable;
                        reg2_read    = ReadEnable;
                        inst_invalid = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_pipe.sv
// Instruction-decode stage: operand forwarding from EX/MEM, load-use stall
// and a valid/ready output register toward execute, with flush.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int AW      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               if_valid,
    input  logic [AW-1:0]      if_pc,
    input  logic [31:0]        if_inst,
    output logic               id_ready,
    output logic               reg1_read_o,
    output logic               reg2_read_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]    reg1_data_i,
    input  logic [XLEN-1:0]    reg2_data_i,
    input  logic               ex_wreg_i,
    input  logic               ex_load_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [XLEN-1:0]    ex_wdata_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [XLEN-1:0]    mem_wdata_i,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [AW-1:0]      pc_o,
    output AluOpBus            aluop_o,
    output AluSelBus           alusel_o,
    output logic [XLEN-1:0]    reg1_o,
    output logic [XLEN-1:0]    reg2_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic               inst_invalid_o
);

    AluOpBus         d_aluop;
    AluSelBus        d_alusel;
    logic            d_wreg;
    logic [4:0]      d_wd;
    logic [XLEN-1:0] d_imm;
    logic            d_invalid;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            stall;
    logic            accept;
    AluOpBus         aluop_r;
    logic            wreg_r;

    id_decode #(.XLEN(XLEN)) u_decode (
        .inst         (if_inst),
        .aluop        (d_aluop),
        .alusel       (d_alusel),
        .wreg         (d_wreg),
        .wd           (d_wd),
        .reg1_read    (reg1_read_o),
        .reg2_read    (reg2_read_o),
        .imm          (d_imm),
        .inst_invalid (d_invalid)
    );

    assign reg1_addr_o = RADDR_W'(if_inst[25:21]);
    assign reg2_addr_o = RADDR_W'(if_inst[20:16]);

    // A load result in EX is not available yet, so it is never forwarded.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic               rd_en,
        input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0]    rf_data,
        input logic [XLEN-1:0]    fallback
    );
        if (!rd_en)                                              return fallback;
        if (addr == '0)                                          return '0;
        if (ex_wreg_i && !ex_load_i && ex_wd_i == addr)          return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == addr)                      return mem_wdata_i;
        return rf_data;
    endfunction

    always_comb begin
        op1 = pick_operand(reg1_read_o, reg1_addr_o, reg1_data_i, '0);
        op2 = pick_operand(reg2_read_o, reg2_addr_o, reg2_data_i, d_imm);
    end

    assign stall = if_valid && ex_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                   ((reg1_read_o && ex_wd_i == reg1_addr_o) ||
                    (reg2_read_o && ex_wd_i == reg2_addr_o));

    assign id_ready = !stall && (!ex_valid || ex_ready);
    assign accept   = if_valid && id_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            ex_valid       <= 1'b0;
            pc_o           <= '0;
            aluop_r        <= EXE_NOP_OP;
            alusel_o       <= EXE_RES_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= RADDR_W'(NOPRegAddr);
            wreg_r         <= 1'b0;
            inst_invalid_o <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid       <= 1'b1;
            pc_o           <= if_pc;
            aluop_r        <= d_aluop;
            alusel_o       <= d_alusel;
            reg1_o         <= op1;
            reg2_o         <= op2;
            wd_o           <= RADDR_W'(d_wd);
            wreg_r         <= d_wreg;
            inst_invalid_o <= d_invalid;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // An empty output slot must never look like a write or a real operation downstream.
    assign aluop_o = ex_valid ? aluop_r : EXE_NOP_OP;
    assign wreg_o  = ex_valid && wreg_r;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: a vector table streamed back to back,
// a scoreboard of accepted instructions, and hand sequences for the corners.
module tb_id_pipe;
    import id_pipe_pkg::*;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int AW      = 32;

    logic               clk = 1'b0;
    logic               rst, flush, if_valid, ex_ready;
    logic [AW-1:0]      if_pc;
    logic [31:0]        if_inst;
    logic               id_ready, reg1_read_o, reg2_read_o;
    logic [RADDR_W-1:0] reg1_addr_o, reg2_addr_o;
    logic [XLEN-1:0]    reg1_data_i, reg2_data_i;
    logic               ex_wreg_i, ex_load_i, mem_wreg_i;
    logic [RADDR_W-1:0] ex_wd_i, mem_wd_i;
    logic [XLEN-1:0]    ex_wdata_i, mem_wdata_i;
    logic               ex_valid, wreg_o, inst_invalid_o;
    logic [AW-1:0]      pc_o;
    AluOpBus            aluop_o;
    AluSelBus           alusel_o;
    logic [XLEN-1:0]    reg1_o, reg2_o;
    logic [RADDR_W-1:0] wd_o;

    always #5 clk = ~clk;

    id_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
        .if_inst(if_inst), .id_ready(id_ready),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .pc_o(pc_o), .aluop_o(aluop_o),
        .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .inst_invalid_o(inst_invalid_o)
    );

    // Regfile model; $0 holds garbage so the stage's own zeroing is exercised.
    logic [XLEN-1:0] rf [32];
    assign reg1_data_i = rf[reg1_addr_o];
    assign reg2_data_i = rf[reg2_addr_o];

    typedef struct packed {
        logic [AW-1:0]      pc;
        AluOpBus            aluop;
        AluSelBus           alusel;
        logic [XLEN-1:0]    reg1;
        logic [XLEN-1:0]    reg2;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic               invalid;
    } exp_t;

    typedef struct {
        logic [31:0]        inst;
        logic               ex_wreg;
        logic               ex_load;
        logic [RADDR_W-1:0] ex_wd;
        logic [XLEN-1:0]    ex_wdata;
        logic               mem_wreg;
        logic [RADDR_W-1:0] mem_wd;
        logic [XLEN-1:0]    mem_wdata;
        exp_t               exp;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    vec_t vecs[14];
    vec_t v, i1, i2, i3, ld_use;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] funct);
        return {EXE_SPECIAL, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input AluOpBus op, input AluSelBus sel,
                                input logic [31:0] r1, r2, input logic [4:0] wd,
                                input logic wreg, inv);
        exp_t e;
        e.pc = pc; e.aluop = op; e.alusel = sel; e.reg1 = r1; e.reg2 = r2;
        e.wd = wd; e.wreg = wreg; e.invalid = inv;
        return e;
    endfunction

    function automatic vec_t mv(input logic [31:0] inst, input logic exw, exl,
                                input logic [4:0] exwd, input logic [31:0] exdata,
                                input logic mw, input logic [4:0] mwd, input logic [31:0] mdata,
                                input exp_t e);
        vec_t r;
        r.inst = inst; r.ex_wreg = exw; r.ex_load = exl; r.ex_wd = exwd; r.ex_wdata = exdata;
        r.mem_wreg = mw; r.mem_wd = mwd; r.mem_wdata = mdata; r.exp = e;
        return r;
    endfunction

    task automatic drive(input vec_t d);
        if_valid    = 1'b1;
        if_inst     = d.inst;
        if_pc       = d.exp.pc;
        ex_wreg_i   = d.ex_wreg;
        ex_load_i   = d.ex_load;
        ex_wd_i     = d.ex_wd;
        ex_wdata_i  = d.ex_wdata;
        mem_wreg_i  = d.mem_wreg;
        mem_wd_i    = d.mem_wd;
        mem_wdata_i = d.mem_wdata;
        cur_exp     = d.exp;
    endtask

    task automatic idle();
        if_valid   = 1'b0;
        ex_wreg_i  = 1'b0;
        ex_load_i  = 1'b0;
        mem_wreg_i = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, ex_valid, 0);
        check({tag, "_wreg"}, wreg_o, 0);
        check({tag, "_invalid"}, inst_invalid_o, 0);
        check({tag, "_aluop"}, aluop_o, EXE_NOP_OP);
        check({tag, "_alusel"}, alusel_o, EXE_RES_NOP);
        check({tag, "_reg1"}, reg1_o, 0);
        check({tag, "_reg2"}, reg2_o, 0);
        check({tag, "_pc"}, pc_o, 0);
        check({tag, "_wd"}, wd_o, NOPRegAddr);
    endtask

    // Scoreboard: compare what execute consumes, then record what ID accepts.
    always @(negedge clk) begin
        if (!rst) begin
            if (ex_valid && ex_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("out_pc", pc_o, mon_e.pc);
                    check("out_aluop", aluop_o, mon_e.aluop);
                    check("out_alusel", alusel_o, mon_e.alusel);
                    check("out_reg1", reg1_o, mon_e.reg1);
                    check("out_reg2", reg2_o, mon_e.reg2);
                    check("out_wd", wd_o, mon_e.wd);
                    check("out_wreg", wreg_o, mon_e.wreg);
                    check("out_invalid", inst_invalid_o, mon_e.invalid);
                end
            end
            if (if_valid && id_ready && !flush) sb.push_back(cur_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + 32'(k) * 32'h0101;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h1234_0000;

        vecs[0]  = mv(itype(EXE_ORI, 1, 2, 16'h00FF), 0, 0, 0, 0, 0, 0, 0,
                      mk(32'h400, EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_00FF, 2, 1, 0));
        vecs[1]  = mv(rtype(2, 2, 3, EXE_OR), 1, 0, 2, 32'hAAAA_0000, 1, 2, 32'h5555,
                      mk(32'h404, EXE_OR_OP, EXE_RES_LOGIC, 32'hAAAA_0000, 32'hAAAA_0000, 3, 1, 0));
        vecs[2]  = mv(rtype(2, 2, 3, EXE_OR), 0, 0, 2, 32'hAAAA_0000, 1, 2, 32'h5555,
                      mk(32'h408, EXE_OR_OP, EXE_RES_LOGIC, 32'h5555, 32'h5555, 3, 1, 0));
        vecs[3]  = mv(rtype(0, 2, 3, EXE_OR), 1, 0, 0, 32'h1111, 1, 0, 32'h2222,
                      mk(32'h40C, EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h1000_0202, 3, 1, 0));
        vecs[4]  = mv(itype(EXE_ANDI, 7, 6, 16'h8001), 0, 0, 0, 0, 0, 0, 0,
                      mk(32'h410, EXE_AND_OP, EXE_RES_LOGIC, 32'h1000_0707, 32'h0000_8001, 6, 1, 0));
        vecs[5]  = mv(itype(EXE_XORI, 9, 8, 16'hFFFF), 1, 0, 9, 32'hCAFE_0000, 1, 9, 32'hBEEF,
                      mk(32'h414, EXE_XOR_OP, EXE_RES_LOGIC, 32'hCAFE_0000, 32'h0000_FFFF, 8, 1, 0));
        vecs[6]  = mv(itype(EXE_LUI, 5, 10, 16'hABCD), 1, 1, 5, 32'h9, 0, 0, 0,
                      mk(32'h418, EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'hABCD_0000, 10, 1, 0));
        vecs[7]  = mv(rtype(12, 13, 11, EXE_AND), 0, 0, 0, 0, 0, 0, 0,
                      mk(32'h41C, EXE_AND_OP, EXE_RES_LOGIC, 32'h1000_0C0C, 32'h1000_0D0D, 11, 1, 0));
        vecs[8]  = mv(rtype(12, 13, 11, EXE_XOR), 0, 0, 0, 0, 1, 13, 32'h600D,
                      mk(32'h420, EXE_XOR_OP, EXE_RES_LOGIC, 32'h1000_0C0C, 32'h600D, 11, 1, 0));
        vecs[9]  = mv(rtype(12, 13, 17, EXE_NOR), 1, 0, 12, 32'h1, 1, 12, 32'h2,
                      mk(32'h424, EXE_NOR_OP, EXE_RES_LOGIC, 32'h1, 32'h1000_0D0D, 17, 1, 0));
        vecs[10] = mv(itype(EXE_LW, 15, 14, 16'hFFFC), 0, 0, 0, 0, 0, 0, 0,
                      mk(32'h428, EXE_LW_OP, EXE_RES_LOAD_STORE, 32'h1000_0F0F, 32'hFFFF_FFFC, 14, 1, 0));
        vecs[11] = mv(itype(EXE_ORI, 1, 2, 16'h0001), 1, 1, 20, 32'h9, 0, 0, 0,
                      mk(32'h42C, EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h1, 2, 1, 0));
        vecs[12] = mv(itype(EXE_ORI, 0, 2, 16'h0005), 1, 1, 0, 32'h9, 0, 0, 0,
                      mk(32'h430, EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h5, 2, 1, 0));
        vecs[13] = mv(itype(6'h3F, 3, 4, 16'h1234), 0, 0, 0, 0, 0, 0, 0,
                      mk(32'h434, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 0, 0, 1));

        i1 = mv(itype(EXE_ORI, 1, 2, 16'h0011), 0, 0, 0, 0, 0, 0, 0,
                mk(32'h900, EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h11, 2, 1, 0));
        i2 = mv(itype(EXE_XORI, 1, 3, 16'h0022), 0, 0, 0, 0, 0, 0, 0,
                mk(32'h904, EXE_XOR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h22, 3, 1, 0));
        i3 = mv(rtype(1, 1, 4, EXE_OR), 0, 0, 0, 0, 0, 0, 0,
                mk(32'h908, EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h1234_0000, 4, 1, 0));
        ld_use = mv(itype(EXE_ANDI, 4, 5, 16'h0001), 1, 1, 4, 32'h99, 0, 0, 0,
                    mk(32'h804, EXE_AND_OP, EXE_RES_LOGIC, 32'h7, 32'h1, 5, 1, 0));

        rst = 1'b0; ex_ready = 1'b1; if_inst = '0; if_pc = '0;
        ex_wd_i = '0; ex_wdata_i = '0; mem_wd_i = '0; mem_wdata_i = '0;
        idle();
        #1 rst = 1'b1;
        #2 check_reset("reset");
        to_drive();
        rst = 1'b0;

        // Back-to-back table stream, first accept in the first cycle out of reset.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), id_ready, 1);
            if (i == 0) check("latency_before", ex_valid, 0);
            if (i == 1) check("latency_after", ex_valid, 1);
            to_drive();
        end
        idle();
        @(negedge clk);
        to_drive();
        check("sb_drained_table", 64'(sb.size()), 0);

        // Load-use: one stall cycle, one bubble, then MEM forwarding.
        v = i1; v.exp.pc = 32'h800;
        drive(v);
        @(negedge clk);
        to_drive();
        drive(ld_use);
        @(negedge clk);
        check("lu_stall_ready", id_ready, 0);
        check("lu_prev_valid", ex_valid, 1);
        to_drive();
        ld_use.ex_wreg = 1'b0; ld_use.ex_load = 1'b0;
        ld_use.mem_wreg = 1'b1; ld_use.mem_wd = 4; ld_use.mem_wdata = 32'h7;
        drive(ld_use);
        @(negedge clk);
        check("lu_bubble", ex_valid, 0);
        check("lu_ready_after", id_ready, 1);
        to_drive();
        idle();
        @(negedge clk);
        check("lu_issue", ex_valid, 1);
        to_drive();

        // Backpressure: three held cycles, then in-order drain.
        drive(i1);
        @(negedge clk);
        to_drive();
        drive(i2);
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_ready", k), id_ready, 0);
            check($sformatf("bp%0d_valid", k), ex_valid, 1);
            check($sformatf("bp%0d_pc", k), pc_o, i1.exp.pc);
            check($sformatf("bp%0d_reg2", k), reg2_o, i1.exp.reg2);
            check($sformatf("bp%0d_wd", k), wd_o, i1.exp.wd);
            to_drive();
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_ready", id_ready, 1);
        to_drive();
        drive(i3);
        @(negedge clk);
        to_drive();
        idle();
        @(negedge clk);
        to_drive();
        @(negedge clk);
        to_drive();
        check("sb_drained_bp", 64'(sb.size()), 0);

        // Flush over a stalled stage with a held output.
        v = i1; v.exp.pc = 32'hA00;
        drive(v);
        @(negedge clk);
        to_drive();
        ld_use.ex_wreg = 1'b1; ld_use.ex_load = 1'b1; ld_use.mem_wreg = 1'b0;
        drive(ld_use);
        ex_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("fl_valid_before", ex_valid, 1);
        check("fl_ready", id_ready, 0);
        to_drive();
        sb.delete();
        idle();
        ex_ready = 1'b1;
        @(negedge clk);
        check("fl_valid_after", ex_valid, 0);
        check("fl_wreg", wreg_o, 0);
        check("fl_aluop", aluop_o, EXE_NOP_OP);
        to_drive();

        // Flush beats an accept in the same cycle; id_ready ignores flush.
        drive(i2);
        flush = 1'b1;
        @(negedge clk);
        check("fla_ready", id_ready, 1);
        to_drive();
        idle();
        @(negedge clk);
        check("fla_valid", ex_valid, 0);
        to_drive();

        // Asynchronous reset in the middle of a stall.
        drive(i1);
        @(negedge clk);
        to_drive();
        drive(ld_use);
        ex_ready = 1'b0;
        @(negedge clk);
        check("rs_valid_before", ex_valid, 1);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        sb.delete();
        to_drive();
        rst = 1'b0;
        idle();
        ex_ready = 1'b1;
        drive(i3);
        @(negedge clk);
        check("rs_first_ready", id_ready, 1);
        to_drive();
        idle();
        @(negedge clk);
        check("rs_first_valid", ex_valid, 1);
        to_drive();
        check("sb_drained_end", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
